// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller: tracks destination registers of in-flight
// instructions and steers decode operand forwarding, load-use stalls and redirect flushes.
module pipeline_hazard_unit #(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  id_inst,
  input  logic                         id_valid,
  input  logic                         ex_redirect,
  input  logic                         hold,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b_sel,
  output logic                         stall_id,
  output logic                         flush_id,
  output logic [CNT_W-1:0]             perf_stall_cnt,
  output logic [CNT_W-1:0]             perf_flush_cnt
);
  localparam int SELW = $clog2(DEPTH + 1);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [4:0]          opcode;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [2:0]          funct3;
  logic                dec_wr;
  logic                dec_load;
  logic                use_rs1;
  logic                use_rs2;
  logic [DEPTH:1]      st_valid;
  logic [DEPTH:1]      st_wr;
  logic [DEPTH:1]      st_load;
  logic [DEPTH:1][4:0] st_rd;
  logic [SELW-1:0]     win_a;
  logic [SELW-1:0]     win_b;
  logic                lu_a;
  logic                lu_b;
  logic                load_use;
  logic                unused_bits;

  assign opcode      = id_inst[6:2];
  assign rs1         = id_inst[19:15];
  assign rs2         = id_inst[24:20];
  assign funct3      = id_inst[14:12];
  assign unused_bits = ^{id_inst[31:25], id_inst[1:0]};

  // Only CSRRW (register source) and CSRRWI (immediate source) are recognised system ops.
  always_comb begin
    dec_wr   = 1'b0;
    dec_load = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_LOAD:              begin dec_wr = 1'b1; dec_load = 1'b1; use_rs1 = 1'b1; end
      OPC_STORE, OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_JALR, OPC_OPIMM:   begin dec_wr = 1'b1; use_rs1 = 1'b1; end
      OPC_JAL, OPC_AUIPC,
      OPC_LUI:               dec_wr = 1'b1;
      OPC_OP:                begin dec_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_SYSTEM: begin
        if (funct3 == 3'b001) begin
          dec_wr  = 1'b1;
          use_rs1 = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Scan oldest to youngest so the youngest matching stage is the last one written.
  always_comb begin
    win_a = '0;
    win_b = '0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_valid && use_rs1 && rs1 != 5'd0 && st_valid[k] && st_wr[k] && st_rd[k] == rs1) begin
        win_a = SELW'(k);
        lu_a  = st_load[k] && (k < LOAD_STAGE);
      end
      if (id_valid && use_rs2 && rs2 != 5'd0 && st_valid[k] && st_wr[k] && st_rd[k] == rs2) begin
        win_b = SELW'(k);
        lu_b  = st_load[k] && (k < LOAD_STAGE);
      end
    end
  end

  assign load_use  = lu_a | lu_b;
  assign stall_id  = load_use & ~ex_redirect;
  assign flush_id  = ex_redirect & rst_n;
  assign fwd_a_sel = load_use ? '0 : win_a;
  assign fwd_b_sel = load_use ? '0 : win_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_wr    <= '0;
      st_load  <= '0;
      st_rd    <= '0;
    end else if (!hold) begin
      for (int k = 2; k <= DEPTH; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_wr[k]    <= st_wr[k-1];
        st_load[k]  <= st_load[k-1];
        st_rd[k]    <= st_rd[k-1];
      end
      if (stall_id || flush_id || !id_valid) begin
        st_valid[1] <= 1'b0;
        st_wr[1]    <= 1'b0;
        st_load[1]  <= 1'b0;
        st_rd[1]    <= 5'd0;
      end else begin
        st_valid[1] <= 1'b1;
        st_wr[1]    <= dec_wr;
        st_load[1]  <= dec_load;
        st_rd[1]    <= id_inst[11:7];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (!hold) begin
      if (stall_id && (perf_stall_cnt != {CNT_W{1'b1}}))
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (flush_id && (perf_flush_cnt != {CNT_W{1'b1}}))
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: directed hazard scenarios followed by
// random instruction streams, compared against a queue-based model of in-flight writers.
module tb_pipeline_hazard_unit;
  localparam int DEPTH      = 3;
  localparam int LOAD_STAGE = 2;
  localparam int CNT_W      = 16;
  localparam int SELW       = $clog2(DEPTH + 1);
  localparam int CNT_MAX    = 65535;
  localparam int SMALL_MAX  = 3;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             ex_redirect;
  logic             hold;
  logic [SELW-1:0]  fwd_a_sel, fwd_b_sel, sm_a_sel, sm_b_sel;
  logic             stall_id, flush_id, sm_stall, sm_flush;
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;
  logic [1:0]       sm_stall_cnt, sm_flush_cnt;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } ent_t;

  ent_t pipe_q[$];
  int   m_stall_cnt;
  int   m_flush_cnt;
  int   exp_a;
  int   exp_b;
  logic exp_stall;
  logic exp_flush;
  logic cur_hold;
  ent_t next_ent;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .hold(hold), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_id(stall_id), .flush_id(flush_id),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  pipeline_hazard_unit #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .hold(hold), .fwd_a_sel(sm_a_sel), .fwd_b_sel(sm_b_sel),
    .stall_id(sm_stall), .flush_id(sm_flush),
    .perf_stall_cnt(sm_stall_cnt), .perf_flush_cnt(sm_flush_cnt)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {7'b0, rs2, rs1, f3, rd, op, 2'b11};
  endfunction

  function automatic void decode(input logic [31:0] inst, output logic wr, output logic ld,
                                 output logic u1, output logic u2);
    logic [3:0] f;
    f = 4'b0000;
    case (inst[6:2])
      OP_LOAD:              f = 4'b1110;
      OP_STORE, OP_BRANCH:  f = 4'b0011;
      OP_JALR, OP_OPIMM:    f = 4'b1010;
      OP_JAL, OP_AUIPC,
      OP_LUI:               f = 4'b1000;
      OP_OP:                f = 4'b1011;
      OP_SYSTEM:            f = (inst[14:12] == 3'b001) ? 4'b1010 :
                                (inst[14:12] == 3'b101) ? 4'b1000 : 4'b0000;
      default:              f = 4'b0000;
    endcase
    {wr, ld, u1, u2} = f;
  endfunction

  // Stage number (1 = youngest) of the first queued writer of rs, 0 if none.
  function automatic int find_stage(input logic [4:0] rs, input logic used, output logic is_ld);
    int hit = 0;
    is_ld = 1'b0;
    if (used && rs != 5'd0) begin
      for (int i = 0; i < pipe_q.size(); i++) begin
        if (hit == 0 && pipe_q[i].valid && pipe_q[i].wr && pipe_q[i].rd == rs) begin
          hit   = i + 1;
          is_ld = pipe_q[i].ld;
        end
      end
    end
    return hit;
  endfunction

  function automatic void model_reset();
    pipe_q.delete();
    for (int i = 0; i < DEPTH; i++) pipe_q.push_back('0);
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endfunction

  function automatic void model_eval(input logic [31:0] inst, input logic v,
                                     input logic redir, input logic hld);
    logic wr, ld, u1, u2, lda, ldb, luse;
    int   ka, kb;
    decode(inst, wr, ld, u1, u2);
    ka   = find_stage(inst[19:15], v && u1, lda);
    kb   = find_stage(inst[24:20], v && u2, ldb);
    luse = (ka != 0 && lda && ka < LOAD_STAGE) || (kb != 0 && ldb && kb < LOAD_STAGE);
    exp_stall = luse && !redir;
    exp_flush = redir;
    exp_a     = luse ? 0 : ka;
    exp_b     = luse ? 0 : kb;
    cur_hold  = hld;
    if (exp_stall || redir || !v) next_ent = '0;
    else                          next_ent = {1'b1, wr, ld, inst[11:7]};
  endfunction

  function automatic void model_advance();
    if (!cur_hold) begin
      if (exp_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (exp_flush && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      pipe_q.push_front(next_ent);
      void'(pipe_q.pop_back());
    end
  endfunction

  function automatic int sat_small(input int v);
    return (v < SMALL_MAX) ? v : SMALL_MAX;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] inst, input logic v,
                                input logic redir, input logic hld);
    id_inst     = inst;
    id_valid    = v;
    ex_redirect = redir;
    hold        = hld;
    #1;
    model_eval(inst, v, redir, hld);
  endtask

  task automatic check_cycle(input string tag);
    check_output({tag, " fwd_a"},      32'(fwd_a_sel),      32'(exp_a));
    check_output({tag, " fwd_b"},      32'(fwd_b_sel),      32'(exp_b));
    check_output({tag, " stall"},      32'(stall_id),       32'(exp_stall));
    check_output({tag, " flush"},      32'(flush_id),       32'(exp_flush));
    check_output({tag, " stall_cnt"},  32'(perf_stall_cnt), 32'(m_stall_cnt));
    check_output({tag, " flush_cnt"},  32'(perf_flush_cnt), 32'(m_flush_cnt));
    check_output({tag, " sm_stall"},   32'(sm_stall),       32'(exp_stall));
    check_output({tag, " sm_fwd_a"},   32'(sm_a_sel),       32'(exp_a));
    check_output({tag, " sm_fwd_b"},   32'(sm_b_sel),       32'(exp_b));
    check_output({tag, " sm_flush"},   32'(sm_flush),       32'(exp_flush));
    check_output({tag, " sm_scnt"},    32'(sm_stall_cnt),   32'(sat_small(m_stall_cnt)));
    check_output({tag, " sm_fcnt"},    32'(sm_flush_cnt),   32'(sat_small(m_flush_cnt)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic step(input logic [31:0] inst, input logic v, input logic redir,
                      input logic hld, input string tag);
    apply_stimulus(inst, v, redir, hld);
    check_cycle(tag);
    tick();
  endtask

  function automatic logic [4:0] rand_op();
    case ($urandom_range(0, 10))
      0:       return OP_LOAD;
      1:       return OP_STORE;
      2:       return OP_BRANCH;
      3:       return OP_JALR;
      4:       return OP_JAL;
      5:       return OP_OP;
      6:       return OP_OPIMM;
      7:       return OP_AUIPC;
      8:       return OP_LUI;
      9:       return OP_SYSTEM;
      default: return 5'b10110;
    endcase
  endfunction

  initial begin
    logic [31:0] lw7, add8, r_inst;
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    id_inst     = '0;
    id_valid    = 1'b0;
    ex_redirect = 1'b0;
    hold        = 1'b0;
    model_reset();
    lw7  = mk(OP_LOAD, 3'b010, 5'd7, 5'd1, 5'd0);
    add8 = mk(OP_OP, 3'b000, 5'd8, 5'd7, 5'd2);

    @(negedge clk);
    apply_stimulus(32'h0, 1'b0, 1'b0, 1'b0);
    check_cycle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ALU dependency forwards from stage 1.
    step(mk(OP_OPIMM, 3'b000, 5'd5, 5'd0, 5'd1), 1'b1, 1'b0, 1'b0, "t1 addi");
    apply_stimulus(mk(OP_OP, 3'b000, 5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
    check_cycle("t1 add");
    check_output("t1 const fwd_a", 32'(fwd_a_sel), 32'd1);
    check_output("t1 const fwd_b", 32'(fwd_b_sel), 32'd1);
    tick();

    // Load-use: one bubble then forward from stage 2.
    step(lw7, 1'b1, 1'b0, 1'b0, "t2 lw");
    apply_stimulus(add8, 1'b1, 1'b0, 1'b0);
    check_cycle("t2 stall");
    check_output("t2 const stall", 32'(stall_id), 32'd1);
    check_output("t2 const fwd_a", 32'(fwd_a_sel), 32'd0);
    tick();
    apply_stimulus(add8, 1'b1, 1'b0, 1'b0);
    check_cycle("t2 release");
    check_output("t2 const fwd_a2", 32'(fwd_a_sel), 32'd2);
    check_output("t2 const scnt", 32'(perf_stall_cnt), 32'd1);
    tick();

    // Youngest writer wins; x0 never forwards.
    step(mk(OP_OPIMM, 3'b000, 5'd3, 5'd0, 5'd5), 1'b1, 1'b0, 1'b0, "t3 w3a");
    step(mk(OP_OPIMM, 3'b000, 5'd11, 5'd0, 5'd5), 1'b1, 1'b0, 1'b0, "t3 w11");
    step(mk(OP_OPIMM, 3'b000, 5'd3, 5'd0, 5'd6), 1'b1, 1'b0, 1'b0, "t3 w3b");
    apply_stimulus(mk(OP_OP, 3'b000, 5'd9, 5'd3, 5'd0), 1'b1, 1'b0, 1'b0);
    check_cycle("t3 read");
    check_output("t3 const fwd_a", 32'(fwd_a_sel), 32'd1);
    tick();
    step(mk(OP_OPIMM, 3'b000, 5'd0, 5'd0, 5'd5), 1'b1, 1'b0, 1'b0, "t3 w0a");
    step(mk(OP_OPIMM, 3'b000, 5'd11, 5'd0, 5'd5), 1'b1, 1'b0, 1'b0, "t3 w11b");
    step(mk(OP_OPIMM, 3'b000, 5'd0, 5'd0, 5'd6), 1'b1, 1'b0, 1'b0, "t3 w0b");
    apply_stimulus(mk(OP_OP, 3'b000, 5'd9, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
    check_cycle("t3 x0");
    check_output("t3 const x0", 32'(fwd_a_sel), 32'd0);
    tick();

    // Redirect beats a pending load-use stall.
    step(lw7, 1'b1, 1'b0, 1'b0, "t4 lw");
    apply_stimulus(add8, 1'b1, 1'b1, 1'b0);
    check_cycle("t4 redirect");
    check_output("t4 const flush", 32'(flush_id), 32'd1);
    check_output("t4 const stall", 32'(stall_id), 32'd0);
    tick();
    apply_stimulus(mk(OP_OP, 3'b000, 5'd13, 5'd8, 5'd7), 1'b1, 1'b0, 1'b0);
    check_cycle("t4 after");
    check_output("t4 const fwd_a", 32'(fwd_a_sel), 32'd0);
    check_output("t4 const fcnt", 32'(perf_flush_cnt), 32'd1);
    tick();

    // Hold freezes tracker and counters with the stall still visible.
    step(lw7, 1'b1, 1'b0, 1'b0, "t5 lw");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(add8, 1'b1, 1'b0, 1'b1);
      check_cycle("t5 hold");
      check_output("t5 const stall", 32'(stall_id), 32'd1);
      check_output("t5 const scnt", 32'(perf_stall_cnt), 32'd1);
      tick();
    end
    step(add8, 1'b1, 1'b0, 1'b0, "t5 stall");
    step(add8, 1'b1, 1'b0, 1'b0, "t5 go");

    // Three more load-use pairs: five stalls in total, two-bit counter saturates.
    for (int i = 0; i < 3; i++) begin
      step(lw7, 1'b1, 1'b0, 1'b0, "t6 lw");
      step(add8, 1'b1, 1'b0, 1'b0, "t6 stall");
      step(add8, 1'b1, 1'b0, 1'b0, "t6 go");
    end
    check_output("t6 const scnt", 32'(perf_stall_cnt), 32'd5);
    check_output("t6 const sm_scnt", 32'(sm_stall_cnt), 32'd3);

    // Reset asserted in the middle of a stall cycle.
    step(lw7, 1'b1, 1'b0, 1'b0, "t6 lw2");
    apply_stimulus(add8, 1'b1, 1'b0, 1'b0);
    check_cycle("t6 prereset");
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6 rst fwd_a", 32'(fwd_a_sel), 32'd0);
    check_output("t6 rst fwd_b", 32'(fwd_b_sel), 32'd0);
    check_output("t6 rst stall", 32'(stall_id), 32'd0);
    check_output("t6 rst flush", 32'(flush_id), 32'd0);
    check_output("t6 rst scnt", 32'(perf_stall_cnt), 32'd0);
    check_output("t6 rst fcnt", 32'(perf_flush_cnt), 32'd0);
    check_output("t6 rst sm_scnt", 32'(sm_stall_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(add8, 1'b1, 1'b0, 1'b0, "t6 post");

    // Random streams over a small register set to make hazards frequent.
    for (int n = 0; n < 400; n++) begin
      r_inst = mk(rand_op(), ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b101,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      step(r_inst, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
